// File: rtl/float_unit_arbiter.sv
// float_unit_arbiter: round-robin sharing of one float adder/subtractor and
// one float multiplier among REQUESTERS clients. The grant is registered and
// one-hot; the granted client's operands are steered onto the shared unit
// inputs, and unit results are broadcast to all clients unconditionally.
// A client may hold both units across several cycles with its lock bit.
// Optional lock watchdog: define FLOAT_ARB_WATCHDOG_EN to enable it. With the
// macro undefined there is no counter and timeout is tied low.
module float_unit_arbiter #(
  parameter int REQUESTERS = 4,
  parameter int LOCK_LIMIT = 15
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic [REQUESTERS-1:0]      req,
  input  logic [REQUESTERS-1:0]      lock,
  input  logic [32*REQUESTERS-1:0]   cl_fadd_a,
  input  logic [32*REQUESTERS-1:0]   cl_fadd_b,
  input  logic [32*REQUESTERS-1:0]   cl_fmul_a,
  input  logic [32*REQUESTERS-1:0]   cl_fmul_b,
  input  logic [REQUESTERS-1:0]      cl_add_sub,
  output logic [31:0]                fadd_a_in,
  output logic [31:0]                fadd_b_in,
  output logic [31:0]                fmul_a_in,
  output logic [31:0]                fmul_b_in,
  output logic                       add_sub,
  input  logic [31:0]                fadd_sub_out,
  input  logic [31:0]                fmul_out,
  output logic [31:0]                res_add,
  output logic [31:0]                res_mul,
  output logic [REQUESTERS-1:0]      grant,
  output logic                       busy,
  output logic                       timeout
);

  localparam int PW = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;

  logic [PW-1:0]         ptr;
  logic [PW-1:0]         grant_idx;
  logic [PW-1:0]         scan_start;
  logic [PW-1:0]         scan_idx;
  logic [REQUESTERS-1:0] next_grant;
  logic                  has_grant;
  logic                  hold_req;
  logic                  force_release;
  logic                  hold;
  logic                  found;

  assign has_grant = |grant;
  assign busy      = has_grant;
  assign hold_req  = |(grant & req & lock);
  assign hold      = hold_req & ~force_release;

  assign res_add = fadd_sub_out;
  assign res_mul = fmul_out;

  // Binary index of the currently granted client (zero when idle).
  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < REQUESTERS; i++) begin
      if (grant[i]) grant_idx = PW'(i);
    end
  end

  // Pick the next grant: the scan starts just past the client whose grant is
  // ending (so it becomes lowest priority), or at ptr when nobody is granted.
  always_comb begin
    if (has_grant) begin
      scan_start = (int'(grant_idx) == REQUESTERS - 1) ? '0 : grant_idx + PW'(1);
    end else begin
      scan_start = ptr;
    end
    next_grant = '0;
    found      = 1'b0;
    scan_idx   = '0;
    for (int k = 0; k < REQUESTERS; k++) begin
      if (int'(scan_start) + k >= REQUESTERS) begin
        scan_idx = PW'(int'(scan_start) + k - REQUESTERS);
      end else begin
        scan_idx = PW'(int'(scan_start) + k);
      end
      if (!found && req[scan_idx]) begin
        next_grant[scan_idx] = 1'b1;
        found                = 1'b1;
      end
    end
  end

  // Grant and priority pointer; a held lock freezes both.
  always_ff @(posedge clk) begin
    if (!clr) begin
      grant <= '0;
      ptr   <= '0;
    end else if (!hold) begin
      grant <= next_grant;
      ptr   <= scan_start;
    end
  end

  // Steer the granted client's operands onto the shared units (zero if idle).
  always_comb begin
    fadd_a_in = '0;
    fadd_b_in = '0;
    fmul_a_in = '0;
    fmul_b_in = '0;
    add_sub   = 1'b0;
    for (int i = 0; i < REQUESTERS; i++) begin
      if (grant[i]) begin
        fadd_a_in = fadd_a_in | cl_fadd_a[32*i +: 32];
        fadd_b_in = fadd_b_in | cl_fadd_b[32*i +: 32];
        fmul_a_in = fmul_a_in | cl_fmul_a[32*i +: 32];
        fmul_b_in = fmul_b_in | cl_fmul_b[32*i +: 32];
        add_sub   = add_sub | cl_add_sub[i];
      end
    end
  end

`ifdef FLOAT_ARB_WATCHDOG_EN
  localparam int CW = ($clog2(LOCK_LIMIT + 1) > 4) ? $clog2(LOCK_LIMIT + 1) : 4;

  logic [CW-1:0] lock_cnt;

  assign force_release = hold_req && (lock_cnt == CW'(LOCK_LIMIT));

  // Count held lock cycles; on reaching the limit the lock is ignored for one
  // edge, the grant rotates and timeout pulses for the following cycle.
  always_ff @(posedge clk) begin
    if (!clr) begin
      lock_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      timeout <= force_release;
      if (hold) lock_cnt <= lock_cnt + CW'(1);
      else      lock_cnt <= '0;
    end
  end
`else
  logic unused_lock_limit;

  assign unused_lock_limit = (LOCK_LIMIT > 0);
  assign force_release     = 1'b0;
  assign timeout           = 1'b0;
`endif

endmodule

// File: doc/float_unit_arbiter.md
# float_unit_arbiter

Round-robin arbiter that shares the single float adder/subtractor and the single float multiplier among up to `REQUESTERS` clients, for example the main FPU instruction path and the reciprocal sequencer. It registers a one-hot grant and steers the granted client's operands onto the shared unit inputs. Results are broadcast to every client. A lock input lets a client hold both units across a multi-cycle sequence such as the 8-step reciprocal.

## Interface
- `REQUESTERS`, default 4: number of clients, legal range 2..8.
- `LOCK_LIMIT`, default 15: watchdog cycle limit, used only when `FLOAT_ARB_WATCHDOG_EN` is defined.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `clr`  in  1  reset; synchronous, active-low, sampled on the `clk` rising edge.
- `req`  in  `REQUESTERS`  per-client request.
- `lock`  in  `REQUESTERS`  per-client hold-grant; only honoured for the currently granted client.
- `cl_fadd_a`, `cl_fadd_b`, `cl_fmul_a`, `cl_fmul_b`  in  `32*REQUESTERS`  packed per-client operands; client i occupies bits `[32i+31:32i]`.
- `cl_add_sub`  in  `REQUESTERS`  per-client adder mode (0 = add, 1 = subtract).
- `fadd_a_in`, `fadd_b_in`, `fmul_a_in`, `fmul_b_in`  out  32  to the shared units.
- `add_sub`  out  1  to the adder.
- `fadd_sub_out`, `fmul_out`  in  32  from the shared units.
- `res_add`, `res_mul`  out  32  results broadcast to all clients.
- `grant`  out  `REQUESTERS`  registered one-hot grant.
- `busy`  out  1  OR of `grant`.
- `timeout`  out  1  watchdog fired; a one-cycle pulse.

## Operation
**State.** The block holds three registers:
- `grant`: one-hot.
- `ptr`: index of the highest-priority client, log2 of `REQUESTERS` bits.
- Watchdog counter: 4+ bits wide, present only with the macro.

**Arbitration (each rising edge, `clr` = 1).**
- If the current grant g has `req[g] & lock[g]` = 1, the grant holds and `ptr` does not change.
- Otherwise a new grant is taken from `req`. The scan runs from `ptr` upward and wraps modulo `REQUESTERS`.
- When a grant to client g ends, `ptr` becomes (g+1) mod `REQUESTERS`. The just-served client therefore has lowest priority.
- A sole requester is regranted back-to-back with no gap.
- If no `req` bit is set, `grant` becomes 0.

**Steering (combinational from the `grant` register).**
- `fadd_*`, `fmul_*` and `add_sub` carry the granted client's inputs.
- With no grant, all operand outputs and `add_sub` are 0.
- `res_add` = `fadd_sub_out` and `res_mul` = `fmul_out`, unconditionally. Clients qualify the results with their own `grant` bit.

**Boundary conditions.**
- `lock` without `req` is ignored.
- `lock` on a non-granted client does nothing until that client is granted.
- A granted client that drops `req` loses the grant at the next edge, even if `lock` is high.
- `req` is expected to stay high while waiting. Dropping it before the grant arrives cancels the request, with no side effects.
- Reset mid-lock clears the grant immediately at that edge. The client sequence must itself reset on the same `clr`.

## Timing
- **Request to grant:** `req` seen at edge N gives `grant` high after edge N (1-cycle latency).
- **Operands to result:** same cycle as the grant, purely combinational through the shared units.
- **Unlocked grant:** lasts exactly one cycle per arbitration win.
- **Locked grant of L cycles:** `lock` is held high through the first L-1 grant cycles. `lock` low in grant cycle L releases the grant at the following edge.
- **Reset values:** `grant` = 0, `ptr` = 0, `busy` = 0, `timeout` = 0, watchdog counter = 0. All operand outputs and `add_sub` are 0.

## Configuration
Macro `FLOAT_ARB_WATCHDOG_EN`.

**Defined:**
- The counter clears on every new grant and increments on every edge where a locked grant is held.
- When the counter reaches `LOCK_LIMIT`, the arbiter forces a release at the next edge, treating the client as unlocked. `ptr` advances and `timeout` pulses high for one cycle.

**Undefined:**
- No counter exists, and locks may be held indefinitely.
- `timeout` is tied to 0.

## Test plan
- **Reset and single request:** hold `clr` = 0 for 2 cycles, then set `req` = 0001. Expect `grant` = 0000 during reset and `grant` = 0001 one edge later. Drive `cl_fmul_a` = 0x40000000 and `cl_fmul_b` = 0x3F800000; expect `res_mul` = 0x40000000.
- **Round-robin fairness:** hold `req` = 1111 with no lock. Expect `grant` sequence 0001, 0010, 0100, 1000, 0001.
- **8-cycle lock:** client 2 holds `req` = 1 with `lock` = 1 for 7 grant cycles while clients 0 and 1 also request. Expect `grant` = 0100 for exactly 8 cycles, then 1000-side priority applied, giving 0001.
- **Early release:** a locked client drops `req` in grant cycle 3. Expect the grant to move to the next requester at the following edge.
- **Reset mid-lock:** pulse `clr` = 0 for one edge while `grant` = 0010 is locked. Expect `grant` = 0000 and `ptr` = 0, then rearbitration from client 0.
- **Watchdog (macro defined, `LOCK_LIMIT` = 15):** hold `lock` and `req` high indefinitely while client 3 also requests. Expect a forced release, a single-cycle `timeout` = 1, and `grant` = 1000 on the next cycle.
